// File: rtl/line_tracker.sv
// line_tracker: reflectance-array line follower. A two-stage pipeline classifies each sample,
// filters class changes, and drives binary motor enables with lost-line search and marker stop.
module line_tracker #(
  parameter  int unsigned NUM_SENSORS  = 8,
  parameter  int unsigned MARKER_MIN   = 6,
  parameter  int unsigned DEADBAND     = 1,
  parameter  int unsigned CONFIRM_CNT  = 3,
  parameter  int unsigned LOST_TIMEOUT = 1000,
  localparam int unsigned POS_W        = $clog2(NUM_SENSORS) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SENSORS-1:0]  sensor_in,
  input  logic                    sample_valid,
  input  logic                    enable,
  input  logic                    clear_stop,
  output logic                    left_motor,
  output logic                    right_motor,
  output logic signed [POS_W-1:0] position,
  output logic                    position_valid,
  output logic                    line_lost,
  output logic                    stop_marker,
  output logic [1:0]              state
);

  localparam int unsigned IDX_W  = $clog2(NUM_SENSORS);
  localparam int unsigned CNT_W  = $clog2(NUM_SENSORS + 1);
  localparam int unsigned CONF_W = $clog2(CONFIRM_CNT + 1);
  localparam int unsigned SRCH_W = $clog2(LOST_TIMEOUT + 1);
  localparam logic signed [POS_W-1:0] DB = POS_W'(DEADBAND);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_LINE   = 2'd1,
    CLS_MARKER = 2'd2,
    CLS_BAD    = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  // Stage-1 combinational sample analysis
  logic [CNT_W-1:0]        cnt_c;
  logic [CNT_W-1:0]        span_c;
  logic [IDX_W-1:0]        min_c;
  logic [IDX_W-1:0]        max_c;
  logic                    found_c;
  cls_e                    cls_c;
  logic signed [POS_W-1:0] raw_c;

  always_comb begin
    cnt_c   = '0;
    min_c   = '0;
    max_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(NUM_SENSORS); i++) begin
      if (sensor_in[i]) begin
        cnt_c = cnt_c + CNT_W'(1);
        if (!found_c) min_c = IDX_W'(i);
        max_c   = IDX_W'(i);
        found_c = 1'b1;
      end
    end
  end

  // Set bits are contiguous exactly when the popcount equals the min..max span
  always_comb begin
    span_c = CNT_W'(max_c) - CNT_W'(min_c) + CNT_W'(1);
    raw_c  = POS_W'(int'(min_c) + int'(max_c) - int'(NUM_SENSORS) + 1);
    if (cnt_c == '0)                          cls_c = CLS_NONE;
    else if (cnt_c >= CNT_W'(MARKER_MIN))     cls_c = CLS_MARKER;
    else if (cnt_c == span_c)                 cls_c = CLS_LINE;
    else                                      cls_c = CLS_BAD;
  end

  logic                    s1_valid_q;
  cls_e                    s1_cls_q;
  logic signed [POS_W-1:0] s1_raw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_NONE;
      s1_raw_q   <= '0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        s1_cls_q <= cls_c;
        s1_raw_q <= raw_c;
      end
    end
  end

  // Motor drive helpers: {left, right}
  function automatic logic [1:0] track_drive(input logic signed [POS_W-1:0] p);
    if (p < -DB)      return 2'b10;
    else if (p > DB)  return 2'b01;
    else              return 2'b11;
  endfunction

  function automatic logic [1:0] search_drive(input logic signed [POS_W-1:0] p);
    if (p[POS_W-1])   return 2'b10;
    else if (p != '0) return 2'b01;
    else              return 2'b11;
  endfunction

  state_e                  state_q, state_d;
  cls_e                    cand_q, cand_d;
  logic [CONF_W-1:0]       conf_q, conf_d;
  logic [SRCH_W-1:0]       srch_q, srch_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    pv_q, pv_d;
  logic                    left_q, left_d;
  logic                    right_q, right_d;
  logic                    lost_q, lost_d;
  logic                    marker_q, marker_d;
  logic                    conf_hit;
  logic                    conf_none, conf_line, conf_marker;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cand_q   <= CLS_NONE;
      conf_q   <= '0;
      srch_q   <= '0;
      pos_q    <= '0;
      pv_q     <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      lost_q   <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      conf_q   <= conf_d;
      srch_q   <= srch_d;
      pos_q    <= pos_d;
      pv_q     <= pv_d;
      left_q   <= left_d;
      right_q  <= right_d;
      lost_q   <= lost_d;
      marker_q <= marker_d;
    end
  end

  // Next-state, persistence filter and registered-output logic
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    conf_d   = conf_q;
    srch_d   = srch_q;
    pos_d    = pos_q;
    pv_d     = 1'b0;
    left_d   = left_q;
    right_d  = right_q;
    lost_d   = lost_q;
    marker_d = marker_q;
    conf_hit = 1'b0;

    if (s1_valid_q) begin
      if (s1_cls_q == CLS_BAD) begin
        conf_d = '0;
      end else if (s1_cls_q == cand_q) begin
        if (conf_q < CONF_W'(CONFIRM_CNT)) conf_d = conf_q + CONF_W'(1);
      end else begin
        cand_d = s1_cls_q;
        conf_d = CONF_W'(1);
      end
      conf_hit = (s1_cls_q != CLS_BAD) && (conf_d == CONF_W'(CONFIRM_CNT));
    end
    conf_none   = conf_hit && (cand_d == CLS_NONE);
    conf_line   = conf_hit && (cand_d == CLS_LINE);
    conf_marker = conf_hit && (cand_d == CLS_MARKER);

    if (!enable) begin
      state_d = ST_IDLE;
      left_d  = 1'b0;
      right_d = 1'b0;
      cand_d  = CLS_NONE;
      conf_d  = '0;
      srch_d  = '0;
    end else begin
      if (clear_stop) begin
        lost_d   = 1'b0;
        marker_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          left_d  = 1'b0;
          right_d = 1'b0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (s1_valid_q) begin
            if (s1_cls_q == CLS_LINE) begin
              pos_d             = s1_raw_q;
              pv_d              = 1'b1;
              {left_d, right_d} = track_drive(s1_raw_q);
            end
            if (conf_none) begin
              state_d           = ST_SEARCH;
              srch_d            = '0;
              {left_d, right_d} = search_drive(pos_q);
            end else if (conf_marker) begin
              state_d  = ST_STOPPED;
              marker_d = 1'b1;
              left_d   = 1'b0;
              right_d  = 1'b0;
            end
          end
        end
        ST_SEARCH: begin
          {left_d, right_d} = search_drive(pos_q);
          if (s1_valid_q) begin
            srch_d = srch_q + SRCH_W'(1);
            // A confirmed class outranks a timeout on the same sample
            if (conf_line) begin
              state_d           = ST_TRACK;
              pos_d             = s1_raw_q;
              pv_d              = 1'b1;
              {left_d, right_d} = track_drive(s1_raw_q);
            end else if (conf_marker) begin
              state_d  = ST_STOPPED;
              marker_d = 1'b1;
              left_d   = 1'b0;
              right_d  = 1'b0;
            end else if (srch_d >= SRCH_W'(LOST_TIMEOUT)) begin
              state_d = ST_STOPPED;
              lost_d  = 1'b1;
              left_d  = 1'b0;
              right_d = 1'b0;
            end
          end
        end
        ST_STOPPED: begin
          left_d  = 1'b0;
          right_d = 1'b0;
          if (clear_stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign left_motor     = left_q;
  assign right_motor    = right_q;
  assign position       = pos_q;
  assign position_valid = pv_q;
  assign line_lost      = lost_q;
  assign stop_marker    = marker_q;
  assign state          = 2'(state_q);

endmodule

// File: tb/tb_line_tracker.sv
// Directed self-checking bench for line_tracker: N=8 tracking/search/stop scenarios plus an N=16 instance.
module tb_line_tracker;

  logic              clk;
  logic              reset_n;
  logic [7:0]        sensor_in;
  logic              sample_valid;
  logic              enable;
  logic              clear_stop;
  logic              left_motor;
  logic              right_motor;
  logic signed [3:0] position;
  logic              position_valid;
  logic              line_lost;
  logic              stop_marker;
  logic [1:0]        state;

  logic [15:0]       sensor16;
  logic              valid16;
  logic              enable16;
  logic              clear16;
  logic              left16;
  logic              right16;
  logic signed [4:0] position16;
  logic              pv16;
  logic              lost16;
  logic              marker16;
  logic [1:0]        state16;

  int checks;
  int failures;

  line_tracker #(.NUM_SENSORS(8), .LOST_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .sensor_in(sensor_in), .sample_valid(sample_valid),
    .enable(enable), .clear_stop(clear_stop), .left_motor(left_motor), .right_motor(right_motor),
    .position(position), .position_valid(position_valid), .line_lost(line_lost),
    .stop_marker(stop_marker), .state(state)
  );

  line_tracker #(.NUM_SENSORS(16), .LOST_TIMEOUT(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .sensor_in(sensor16), .sample_valid(valid16),
    .enable(enable16), .clear_stop(clear16), .left_motor(left16), .right_motor(right16),
    .position(position16), .position_valid(pv16), .line_lost(lost16),
    .stop_marker(marker16), .state(state16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe on the N=8 instance; returns at the negedge where its stage-2 result is visible
  task automatic send(input logic [7:0] v);
    @(negedge clk);
    sensor_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; sensor_in = '0; sample_valid = 1'b0; enable = 1'b0; clear_stop = 1'b0;
    sensor16 = '0; valid16 = 1'b0; enable16 = 1'b0; clear16 = 1'b0;
    #12;
    check("rst_state", state, 0);
    check("rst_motors", {left_motor, right_motor}, 0);
    check("rst_flags", {position_valid, line_lost, stop_marker}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 1: enable goes straight to TRACK; centred line
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check("s1_track", state, 1);
    send(8'b00011000);
    check("s1_pos", position, 0);
    check("s1_pv", position_valid, 1);
    check("s1_mot", {left_motor, right_motor}, 3);

    // Scenario 2: extreme and off-centre positions
    send(8'b00000001);
    check("s2_pos_m7", position, -7);
    check("s2_mot_m7", {left_motor, right_motor}, 2);
    send(8'b11000000);
    check("s2_pos_p6", position, 6);
    check("s2_mot_p6", {left_motor, right_motor}, 1);
    send(8'b00110000);
    check("s2_pos_p2", position, 2);
    check("s2_mot_p2", {left_motor, right_motor}, 1);

    // Scenario 3: lost line, search, timeout, clear
    send(8'b00000001);
    check("s3_pos", position, -7);
    send(8'h00); send(8'h00);
    check("s3_two_zero", state, 1);
    send(8'h00);
    check("s3_search", state, 2);
    check("s3_search_mot", {left_motor, right_motor}, 2);
    send(8'h00); send(8'h00); send(8'h00);
    check("s3_search_hold", state, 2);
    send(8'h00);
    check("s3_stopped", state, 3);
    check("s3_lost", line_lost, 1);
    check("s3_stop_mot", {left_motor, right_motor}, 0);
    @(negedge clk); clear_stop = 1'b1;
    @(negedge clk); clear_stop = 1'b0;
    check("s3_clr_idle", state, 0);
    check("s3_clr_lost", line_lost, 0);
    @(negedge clk);
    check("s3_retrack", state, 1);

    // Scenario 4: BAD resets the filter; reacquire from SEARCH
    send(8'b00011000);
    check("s4_pos0", position, 0);
    send(8'h00); send(8'b10000001); send(8'h00); send(8'h00);
    check("s4_bad_hold", state, 1);
    send(8'h00);
    check("s4_search", state, 2);
    check("s4_search_mot", {left_motor, right_motor}, 3);
    send(8'b00001100); send(8'b00001100);
    check("s4_unconf", state, 2);
    check("s4_unconf_pos", position, 0);
    send(8'b00001100);
    check("s4_track", state, 1);
    check("s4_pos", position, -2);
    check("s4_pv", position_valid, 1);
    check("s4_mot", {left_motor, right_motor}, 2);

    // Scenario 5: stop marker, then enable drop keeps sticky flag
    send(8'b11111100); send(8'b11111100);
    check("s5_unconf", state, 1);
    check("s5_hold_pos", position, -2);
    send(8'b11111100);
    check("s5_stopped", state, 3);
    check("s5_marker", stop_marker, 1);
    check("s5_mot", {left_motor, right_motor}, 0);
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("s5_idle", state, 0);
    check("s5_marker_kept", stop_marker, 1);
    enable = 1'b1;
    @(negedge clk);
    check("s5_track", state, 1);
    clear_stop = 1'b1;
    @(negedge clk); clear_stop = 1'b0;
    check("s5_clr_flag", stop_marker, 0);
    check("s5_clr_state", state, 1);

    // Scenario 6: async reset mid-SEARCH
    send(8'h00); send(8'h00); send(8'h00);
    check("s6_search", state, 2);
    check("s6_search_mot", {left_motor, right_motor}, 2);
    #2 reset_n = 1'b0;
    #1;
    check("s6_rst_state", state, 0);
    check("s6_rst_mot", {left_motor, right_motor}, 0);
    check("s6_rst_pos", position, 0);
    @(negedge clk); reset_n = 1'b1;

    // N=16 instance: full-range position and back-to-back strobes
    @(negedge clk); enable16 = 1'b1;
    @(negedge clk);
    check("n16_track", state16, 1);
    sensor16 = 16'h8000; valid16 = 1'b1;
    @(negedge clk); valid16 = 1'b0;
    @(negedge clk);
    check("n16_pos", position16, 15);
    check("n16_pv", pv16, 1);
    check("n16_mot", {left16, right16}, 1);
    sensor16 = 16'h0001; valid16 = 1'b1;
    @(negedge clk); sensor16 = 16'h0003;
    @(negedge clk); valid16 = 1'b0;
    check("n16_b2b_a", position16, -15);
    @(negedge clk);
    check("n16_b2b_b", position16, -14);
    check("n16_b2b_pv", pv16, 1);
    check("n16_b2b_mot", {left16, right16}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
